// File: rtl/hex_loader_pkg.sv
// Shared types and constants for the Intel HEX flash loader.
package hex_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN,
    ST_ADDR,
    ST_TYPE,
    ST_DATA,
    ST_CSUM,
    ST_WRITE,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam logic [7:0] REC_DATA   = 8'h00;
  localparam logic [7:0] REC_EOF    = 8'h01;
  localparam logic [7:0] START_CODE = 8'h3A;

endpackage

// File: rtl/hex_ascii_nibble.sv
// ASCII hex digit decoder. Lowercase 'a'-'f' accepted only when
// HEXLOAD_LOWERCASE_EN is defined.
module hex_ascii_nibble (
  input  logic [7:0] ch,
  output logic [3:0] nib_c,
  output logic       is_hex_c
);

  always_comb begin
    nib_c    = 4'h0;
    is_hex_c = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nib_c    = 4'(ch - 8'h30);
      is_hex_c = 1'b1;
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      nib_c    = 4'(ch - 8'h37);
      is_hex_c = 1'b1;
    end
`ifdef HEXLOAD_LOWERCASE_EN
    else if (ch >= 8'h61 && ch <= 8'h66) begin
      nib_c    = 4'(ch - 8'h57);
      is_hex_c = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/hex_flash_loader.sv
// Intel HEX stream parser that programs 16-bit flash words and holds the core
// in reset until a good EOF record. Optional macro: HEXLOAD_LOWERCASE_EN.
module hex_flash_loader
  import hex_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 16,
  parameter logic [7:0]  BLANK_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_data,
  output logic              flash_wren,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_written
);

  // One extra bit so the word address is byte_addr[ADDR_W:1].
  localparam int unsigned BA_W = ADDR_W + 1;

  state_t state, state_nxt;

  logic              in_ready_nxt, flash_wren_nxt, cpu_hold_nxt, done_nxt, error_nxt;
  logic [ADDR_W-1:0] flash_addr_nxt, words_nxt, word_addr, word_addr_nxt;
  logic [DATA_W-1:0] flash_data_nxt;
  logic [7:0]        sum, sum_nxt, len, len_nxt, fcnt, fcnt_nxt;
  logic [7:0]        addr_hi, addr_hi_nxt, rtype, rtype_nxt, hi_byte, hi_byte_nxt;
  logic [3:0]        hi_nib, hi_nib_nxt;
  logic              phase, phase_nxt, pending, pending_nxt, ret_csum, ret_csum_nxt;
  logic [BA_W-1:0]   baddr, baddr_nxt;

  logic [3:0]        nib_c;
  logic              is_hex_c;
  logic              accept_c;
  logic [7:0]        byte_c;
  logic              last_c;
  logic [ADDR_W-1:0] words_inc_c;

  hex_ascii_nibble u_nibble (
    .ch       (in_data),
    .nib_c    (nib_c),
    .is_hex_c (is_hex_c)
  );

  assign accept_c    = in_valid & in_ready;
  assign byte_c      = {hi_nib, nib_c};
  assign last_c      = (fcnt == len - 8'd1);
  assign words_inc_c = (&words_written) ? words_written : words_written + ADDR_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    flash_wren_nxt = 1'b0;
    flash_addr_nxt = flash_addr;
    flash_data_nxt = flash_data;
    cpu_hold_nxt   = cpu_hold;
    done_nxt       = done;
    error_nxt      = error;
    words_nxt      = words_written;
    word_addr_nxt  = word_addr;
    sum_nxt        = sum;
    len_nxt        = len;
    fcnt_nxt       = fcnt;
    addr_hi_nxt    = addr_hi;
    rtype_nxt      = rtype;
    hi_byte_nxt    = hi_byte;
    hi_nib_nxt     = hi_nib;
    phase_nxt      = phase;
    pending_nxt    = pending;
    ret_csum_nxt   = ret_csum;
    baddr_nxt      = baddr;

    case (state)
      ST_IDLE: begin
        if (accept_c && in_data == START_CODE) begin
          state_nxt = ST_LEN;
          sum_nxt   = 8'h00;
          phase_nxt = 1'b0;
        end
      end

      ST_LEN, ST_ADDR, ST_TYPE, ST_DATA, ST_CSUM: begin
        if (accept_c) begin
          if (!is_hex_c) begin
            error_nxt   = 1'b1;
            pending_nxt = 1'b0;
            state_nxt   = ST_IDLE;
          end else if (!phase) begin
            hi_nib_nxt = nib_c;
            phase_nxt  = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            sum_nxt   = sum + byte_c;
            case (state)
              ST_LEN: begin
                len_nxt   = byte_c;
                fcnt_nxt  = 8'd0;
                state_nxt = ST_ADDR;
              end
              ST_ADDR: begin
                if (fcnt == 8'd0) begin
                  addr_hi_nxt = byte_c;
                  fcnt_nxt    = 8'd1;
                end else begin
                  baddr_nxt = BA_W'({addr_hi, byte_c});
                  state_nxt = ST_TYPE;
                end
              end
              ST_TYPE: begin
                rtype_nxt   = byte_c;
                fcnt_nxt    = 8'd0;
                hi_byte_nxt = BLANK_BYTE;
                pending_nxt = 1'b0;
                state_nxt   = (len == 8'd0) ? ST_CSUM : ST_DATA;
              end
              ST_DATA: begin
                fcnt_nxt  = fcnt + 8'd1;
                baddr_nxt = baddr + BA_W'(1);
                state_nxt = last_c ? ST_CSUM : ST_DATA;
                if (rtype == REC_DATA) begin
                  if (!baddr[0]) begin
                    hi_byte_nxt   = byte_c;
                    pending_nxt   = 1'b1;
                    word_addr_nxt = baddr[ADDR_W:1];
                  end else begin
                    // Odd byte completes the word; an odd-start record keeps the blank high half.
                    flash_wren_nxt = 1'b1;
                    flash_addr_nxt = baddr[ADDR_W:1];
                    flash_data_nxt = DATA_W'({hi_byte, byte_c});
                    words_nxt      = words_inc_c;
                    hi_byte_nxt    = BLANK_BYTE;
                    pending_nxt    = 1'b0;
                    ret_csum_nxt   = last_c;
                    state_nxt      = ST_WRITE;
                  end
                end
              end
              ST_CSUM: begin
                if (sum_nxt != 8'h00) begin
                  error_nxt = 1'b1;
                end
                if (rtype == REC_EOF) begin
                  if (sum_nxt == 8'h00) begin
                    done_nxt     = 1'b1;
                    cpu_hold_nxt = error;
                    state_nxt    = ST_DONE;
                  end else begin
                    state_nxt = ST_IDLE;
                  end
                end else if (pending) begin
                  flash_wren_nxt = 1'b1;
                  flash_addr_nxt = word_addr;
                  flash_data_nxt = DATA_W'({hi_byte, BLANK_BYTE});
                  words_nxt      = words_inc_c;
                  pending_nxt    = 1'b0;
                  state_nxt      = ST_FLUSH;
                end else begin
                  state_nxt = ST_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      end

      ST_WRITE: state_nxt = ret_csum ? ST_CSUM : ST_DATA;
      ST_FLUSH: state_nxt = ST_IDLE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase

    in_ready_nxt = !(state_nxt inside {ST_WRITE, ST_FLUSH, ST_DONE});
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      in_ready      <= 1'b1;
      flash_wren    <= 1'b0;
      flash_addr    <= '0;
      flash_data    <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
      word_addr     <= '0;
      sum           <= 8'h00;
      len           <= 8'h00;
      fcnt          <= 8'h00;
      addr_hi       <= 8'h00;
      rtype         <= 8'h00;
      hi_byte       <= BLANK_BYTE;
      hi_nib        <= 4'h0;
      phase         <= 1'b0;
      pending       <= 1'b0;
      ret_csum      <= 1'b0;
      baddr         <= '0;
    end else begin
      state         <= state_nxt;
      in_ready      <= in_ready_nxt;
      flash_wren    <= flash_wren_nxt;
      flash_addr    <= flash_addr_nxt;
      flash_data    <= flash_data_nxt;
      cpu_hold      <= cpu_hold_nxt;
      done          <= done_nxt;
      error         <= error_nxt;
      words_written <= words_nxt;
      word_addr     <= word_addr_nxt;
      sum           <= sum_nxt;
      len           <= len_nxt;
      fcnt          <= fcnt_nxt;
      addr_hi       <= addr_hi_nxt;
      rtype         <= rtype_nxt;
      hi_byte       <= hi_byte_nxt;
      hi_nib        <= hi_nib_nxt;
      phase         <= phase_nxt;
      pending       <= pending_nxt;
      ret_csum      <= ret_csum_nxt;
      baddr         <= baddr_nxt;
    end
  end

endmodule

// File: tb/tb_hex_flash_loader.sv
// Self-checking bench for hex_flash_loader: directed record table, reset and
// EOF timing sequences, then random records against a record-level model.
module tb_hex_flash_loader;

  localparam int unsigned ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] flash_addr;
  logic [15:0]       flash_data;
  logic              flash_wren;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] words_written;

  hex_flash_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .flash_addr    (flash_addr),
    .flash_data    (flash_data),
    .flash_wren    (flash_wren),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [29:0] act_q[$];
  logic [29:0] exp_q[$];
  int          stall = 0;
  bit          m_err, m_done, m_hold;
  int          m_words;

  // Observed writes ({addr, data}) and stall cycles.
  always @(negedge clk) begin
    if (rst_n && flash_wren) act_q.push_back({flash_addr, flash_data});
    if (rst_n && !in_ready) stall++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    int waits;
    waits = 0;
    in_data  = c;
    in_valid = 1'b1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: in_ready stuck low for char %0h", c);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_model();
    act_q.delete();
    exp_q.delete();
    stall   = 0;
    m_err   = 1'b0;
    m_done  = 1'b0;
    m_hold  = 1'b1;
    m_words = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
`ifdef HEXLOAD_LOWERCASE_EN
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
`endif
    return -1;
  endfunction

  // Record-level reference: decode the text into bytes, then apply the layout rules.
  task automatic model_rec(input string s);
    logic [7:0] b[$];
    bit         bad, ph, complete, have;
    logic [3:0] hi;
    logic [7:0] hb, sum;
    int         v, nd, base, ba, wd, pw;
    bad = 0; ph = 0; hi = 4'h0; have = 0; hb = 8'hFF; pw = 0; sum = 8'h00;
    for (int i = 1; i < s.len(); i++) begin
      if (b.size() >= 1 && b.size() == 5 + int'(b[0])) break;
      v = hexval(s[i]);
      if (v < 0) begin
        bad = 1;
        break;
      end
      if (!ph) begin
        hi = 4'(v);
        ph = 1;
      end else begin
        b.push_back({hi, 4'(v)});
        ph = 0;
      end
    end
    complete = !bad && b.size() >= 5 && b.size() == 5 + int'(b[0]);
    if (b.size() >= 4 && b[3] == 8'h00) begin
      nd = b.size() - 4;
      if (nd > int'(b[0])) nd = int'(b[0]);
      base = int'({b[1], b[2]});
      for (int j = 0; j < nd; j++) begin
        ba = base + j;
        wd = (ba / 2) % 16384;
        if (ba % 2 == 0) begin
          hb = b[4+j];
          have = 1;
          pw = wd;
        end else begin
          exp_q.push_back({14'(wd), (have ? hb : 8'hFF), b[4+j]});
          m_words++;
          have = 0;
        end
      end
      if (complete && have) begin
        exp_q.push_back({14'(pw), hb, 8'hFF});
        m_words++;
      end
    end
    if (bad) m_err = 1'b1;
    else if (complete) begin
      foreach (b[k]) sum = sum + b[k];
      if (sum != 8'h00) m_err = 1'b1;
      else if (b[3] == 8'h01) begin
        m_done = 1'b1;
        m_hold = m_err;
      end
    end
  endtask

  task automatic cmp_writes(input string tag);
    int n;
    check({tag, "_nwrites"}, 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_write"}, 32'(act_q[i]), 32'(exp_q[i]));
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic rand_record(output string s);
    logic [7:0] bytes[$];
    logic [7:0] sum, bc;
    logic [15:0] addr;
    int len, sel, p;
    logic [7:0] badc[5];
    badc = '{8'h47, 8'h67, 8'h20, 8'h2E, 8'h63};
    len  = $urandom_range(0, 6);
    addr = 16'($urandom);
    sel  = $urandom_range(0, 9);
    bytes.push_back(8'(len));
    bytes.push_back(addr[15:8]);
    bytes.push_back(addr[7:0]);
    bytes.push_back(sel < 7 ? 8'h00 : (sel == 7 ? 8'h02 : (sel == 8 ? 8'h04 : 8'h03)));
    for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
    sum = 8'h00;
    foreach (bytes[i]) sum = sum + bytes[i];
    sum = 8'h00 - sum;
    if ($urandom_range(0, 4) == 0) sum = sum ^ 8'h5A;
    bytes.push_back(sum);
    s = ":";
    foreach (bytes[i]) s = {s, $sformatf("%02X", bytes[i])};
    if ($urandom_range(0, 6) == 0) begin
      p  = $urandom_range(1, s.len() - 1);
      bc = badc[$urandom_range(0, 4)];
      if (hexval(bc) >= 0) bc = 8'h47;
      s = {s.substr(0, p - 1), $sformatf("%c", bc)};
    end
  endtask

  typedef struct {
    bit          pre_reset;
    string       rec;
    int          nw;
    logic [29:0] w0;
    logic [29:0] w1;
    bit          err;
    bit          dn;
    bit          hold;
    int          words;
    int          stl;
  } vec_t;

  vec_t vt[12];

  initial begin
    string s;
    vt[0]  = '{1, ":020000000C945E", 1, {14'd0, 16'h0C94}, 30'd0, 0, 0, 1, 1, 1};
    vt[1]  = '{0, ":020010001122BB", 1, {14'd8, 16'h1122}, 30'd0, 0, 0, 1, 2, 1};
    vt[2]  = '{0, ":01000400AA51",   1, {14'd2, 16'hAAFF}, 30'd0, 0, 0, 1, 3, 1};
    vt[3]  = '{0, ":00000001FF",     0, 30'd0, 30'd0, 0, 1, 0, 3, -1};
    vt[4]  = '{1, ":020000000C9400", 1, {14'd0, 16'h0C94}, 30'd0, 1, 0, 1, 1, 1};
    vt[5]  = '{0, ":00000001FF",     0, 30'd0, 30'd0, 1, 1, 1, 1, -1};
    vt[6]  = '{1, ":02G0",           0, 30'd0, 30'd0, 1, 0, 1, 0, 0};
    vt[7]  = '{0, ":00000001FF",     0, 30'd0, 30'd0, 1, 1, 1, 0, -1};
    vt[8]  = '{1, ":03000100AABBCCCB", 2, {14'd0, 16'hFFAA}, {14'd1, 16'hBBCC}, 0, 0, 1, 2, 2};
    vt[9]  = '{0, ":020000020000FC", 0, 30'd0, 30'd0, 0, 0, 1, 2, 0};
    vt[10] = '{0, ":02FFFE001234BB", 1, {14'h3FFF, 16'h1234}, 30'd0, 0, 0, 1, 3, 1};
`ifdef HEXLOAD_LOWERCASE_EN
    vt[11] = '{1, ":01000000ab54",   1, {14'd0, 16'hABFF}, 30'd0, 0, 0, 1, 1, 1};
`else
    vt[11] = '{1, ":01000000ab",     0, 30'd0, 30'd0, 1, 0, 1, 0, 0};
`endif

    do_reset();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_cpu_hold", 32'(cpu_hold), 32'd1);
    check("reset_words", 32'(words_written), 32'd0);

    for (int r = 0; r < 12; r++) begin
      if (vt[r].pre_reset) do_reset();
      act_q.delete();
      stall = 0;
      send_str(vt[r].rec);
      check($sformatf("row%0d_nwrites", r), 32'(act_q.size()), 32'(vt[r].nw));
      if (vt[r].nw >= 1 && act_q.size() >= 1) check($sformatf("row%0d_w0", r), 32'(act_q[0]), 32'(vt[r].w0));
      if (vt[r].nw >= 2 && act_q.size() >= 2) check($sformatf("row%0d_w1", r), 32'(act_q[1]), 32'(vt[r].w1));
      check($sformatf("row%0d_error", r), 32'(error), 32'(vt[r].err));
      check($sformatf("row%0d_done", r), 32'(done), 32'(vt[r].dn));
      check($sformatf("row%0d_cpu_hold", r), 32'(cpu_hold), 32'(vt[r].hold));
      check($sformatf("row%0d_words", r), 32'(words_written), 32'(vt[r].words));
      if (vt[r].stl >= 0) check($sformatf("row%0d_stall", r), 32'(stall), 32'(vt[r].stl));
    end

    // Reset in the middle of a record discards it.
    send_str(":020010001122BB");
    act_q.delete();
    for (int i = 0; i < 8; i++) send_char(8'(":0200000" >> (8 * (7 - i))));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_wren", 32'(flash_wren), 32'd0);
    check("midrst_addr", 32'(flash_addr), 32'd0);
    check("midrst_data", 32'(flash_data), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_words", 32'(words_written), 32'd0);
    check("midrst_nowrite", 32'(act_q.size()), 32'd0);
    reset_model();
    model_rec(":020000000C945E");
    send_str(":020000000C945E");
    cmp_writes("midrst_after");
    check("midrst_after_words", 32'(words_written), 32'(m_words));

    // cpu_hold drops on the cycle after the final EOF character.
    do_reset();
    s = ":00000001F";
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    check("eof_hold_before", 32'(cpu_hold), 32'd1);
    check("eof_done_before", 32'(done), 32'd0);
    send_char(8'h46);
    check("eof_hold_after", 32'(cpu_hold), 32'd0);
    check("eof_done_after", 32'(done), 32'd1);
    check("eof_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("done_sticky_ready", 32'(in_ready), 32'd0);

    // Random records against the model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      rand_record(s);
      model_rec(s);
      send_str(s);
      cmp_writes($sformatf("rand%0d", n));
      check($sformatf("rand%0d_error", n), 32'(error), 32'(m_err));
      check($sformatf("rand%0d_words", n), 32'(words_written), 32'(m_words));
      check($sformatf("rand%0d_done", n), 32'(done), 32'(m_done));
    end
    model_rec(":00000001FF");
    send_str(":00000001FF");
    check("rand_eof_done", 32'(done), 32'(m_done));
    check("rand_eof_hold", 32'(cpu_hold), 32'(m_hold));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
